// File: rtl/tdm_transmit.sv
// TDM serial transmitter: shifts SLOTS samples out MSB first on sck falls, framed by ws.
// sck/ws are same-domain levels; edges come from a registered copy of sck.
module tdm_transmit #(
    parameter int SLOTS        = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   sck_in,
    input  logic                                   ws_in,
    input  logic [SLOTS-1:0][SAMPLE_WIDTH-1:0]     audio_in,
    input  logic                                   valid_in,
    output logic                                   sd_out,
    output logic                                   sd_oe_out,
    output logic                                   busy_out,
    output logic                                   frame_done_out,
    output logic                                   underrun_out,
    output logic                                   resync_out
);

    localparam int FRAME_BITS = SLOTS * SLOT_WIDTH;
    localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t                               state_q;
    logic                                 sck_prev_q;
    logic [SLOTS-1:0][SAMPLE_WIDTH-1:0]   pending_q;
    logic                                 pending_fresh_q;
    logic [FRAME_BITS-1:0]                frame_q;
    logic [FRAME_BITS-1:0]                frame_load_d;
    logic [CNT_W-1:0]                     bit_cnt_q;
    logic                                 ws_seen_q;
    logic                                 sd_q, sd_oe_q, busy_q;
    logic                                 frame_done_q, underrun_q, resync_q;
    logic                                 rise, fall, load;

    assign rise = sck_in & ~sck_prev_q;
    assign fall = ~sck_in & sck_prev_q;

    // A new frame starts from ARMED, or back-to-back when ws landed in the last bit.
    assign load = fall && ((state_q == ARMED) ||
                           (state_q == SHIFT && bit_cnt_q == LAST && ws_seen_q));

    // Slot 0 occupies the top of the frame; each sample is left-justified, tail zero.
    always_comb begin
        frame_load_d = '0;
        for (int k = 0; k < SLOTS; k++) begin
            frame_load_d[(SLOTS-k)*SLOT_WIDTH-1 -: SLOT_WIDTH] =
                SLOT_WIDTH'(pending_q[k]) << (SLOT_WIDTH - SAMPLE_WIDTH);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            sck_prev_q      <= 1'b0;
            pending_q       <= '0;
            pending_fresh_q <= 1'b0;
            frame_q         <= '0;
            bit_cnt_q       <= '0;
            ws_seen_q       <= 1'b0;
            sd_q            <= 1'b0;
            sd_oe_q         <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            underrun_q      <= 1'b0;
            resync_q        <= 1'b0;
        end else begin
            sck_prev_q   <= sck_in;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            resync_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rise && ws_in) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: ;
                SHIFT: begin
                    if (rise && ws_in) begin
                        if (bit_cnt_q == LAST) begin
                            ws_seen_q <= 1'b1;
                        end else begin
                            resync_q <= 1'b1;
                            state_q  <= ARMED;
                        end
                    end
                    if (fall) begin
                        if (bit_cnt_q != LAST) begin
                            sd_q      <= frame_q[FRAME_BITS-1];
                            frame_q   <= frame_q << 1;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end else begin
                            frame_done_q <= 1'b1;
                            ws_seen_q    <= 1'b0;
                            if (!ws_seen_q) begin
                                state_q <= IDLE;
                                sd_q    <= 1'b0;
                                sd_oe_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                state_q         <= SHIFT;
                sd_q            <= frame_load_d[FRAME_BITS-1];
                frame_q         <= frame_load_d << 1;
                sd_oe_q         <= 1'b1;
                busy_q          <= 1'b1;
                bit_cnt_q       <= '0;
                underrun_q      <= ~pending_fresh_q;
                pending_fresh_q <= 1'b0;
            end

            // Placed after the load so a same-clk sample stays fresh for the next frame.
            if (valid_in) begin
                pending_q       <= audio_in;
                pending_fresh_q <= 1'b1;
            end
        end
    end

    assign sd_out         = sd_q;
    assign sd_oe_out      = sd_oe_q;
    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;
    assign underrun_out   = underrun_q;
    assign resync_out     = resync_q;

endmodule
